// File: rtl/aes_key_loader.sv
// Parses MM2S control packets into a 256-bit AES key and commits it while the AES datapath is idle.
// Optional AES_KEY_BSWAP_EN byte-reverses each key word before it reaches the shadow register.
module aes_key_loader #(
    parameter int C_M_AXIS_MM2S_CNTRL_TDATA_WIDTH = 32,
    parameter int C_KEY_WORDS                     = 8,
    parameter int C_ERR_CNT_WIDTH                 = 8
) (
    input  logic                          m_axi_mm2s_aclk,
    input  logic                          mm2s_cntrl_reset_out_n,
    input  logic [31:0]                   m_axis_mm2s_cntrl_tdata,
    input  logic [3:0]                    m_axis_mm2s_cntrl_tkeep,
    input  logic                          m_axis_mm2s_cntrl_tvalid,
    input  logic                          m_axis_mm2s_cntrl_tlast,
    output logic                          m_axis_mm2s_cntrl_tready,
    input  logic                          aes_idle,
    output logic [C_KEY_WORDS*32-1:0]     aes_key,
    output logic                          aes_key_valid,
    output logic                          aes_key_update,
    output logic [C_ERR_CNT_WIDTH-1:0]    aes_key_err_cnt,
    output logic                          aes_key_busy
);

    localparam int KEY_W = C_KEY_WORDS * 32;
    localparam int CNT_W = (C_KEY_WORDS > 1) ? $clog2(C_KEY_WORDS) : 1;

    typedef enum logic [1:0] {S_HDR, S_KEY, S_DRAIN, S_COMMIT} state_t;

    state_t             state, next;
    logic [CNT_W-1:0]   cnt;
    logic [KEY_W-1:0]   shadow;
    logic               pend_load;
    logic               accept, hdr_ok, last_word;
    logic               err_inc, cnt_clr, store, pend_set, pend_load_d, commit;
    logic [31:0]        key_word;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

`ifdef AES_KEY_BSWAP_EN
    assign key_word = bswap32(m_axis_mm2s_cntrl_tdata);
`else
    assign key_word = m_axis_mm2s_cntrl_tdata;
`endif

    // tready is forced low while reset is held so nothing is accepted during reset
    assign m_axis_mm2s_cntrl_tready = mm2s_cntrl_reset_out_n & (state != S_COMMIT);
    assign aes_key_busy = (state != S_HDR);
    assign accept       = m_axis_mm2s_cntrl_tvalid & m_axis_mm2s_cntrl_tready;
    assign hdr_ok       = (m_axis_mm2s_cntrl_tdata[31:28] == 4'hA) && (m_axis_mm2s_cntrl_tkeep == 4'hF);
    assign last_word    = (int'(cnt) == C_KEY_WORDS - 1);

    always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_cntrl_reset_out_n) begin
        if (!mm2s_cntrl_reset_out_n) state <= S_HDR;
        else                         state <= next;
    end

    always_comb begin
        next        = state;
        err_inc     = 1'b0;
        cnt_clr     = 1'b0;
        store       = 1'b0;
        pend_set    = 1'b0;
        pend_load_d = pend_load;
        commit      = 1'b0;
        case (state)
            S_HDR: if (accept) begin
                if (hdr_ok && m_axis_mm2s_cntrl_tdata[7:0] == 8'h01 && !m_axis_mm2s_cntrl_tlast) begin
                    next    = S_KEY;
                    cnt_clr = 1'b1;
                end else if (hdr_ok && m_axis_mm2s_cntrl_tdata[7:0] == 8'h02 && m_axis_mm2s_cntrl_tlast) begin
                    next        = S_COMMIT;
                    pend_set    = 1'b1;
                    pend_load_d = 1'b0;
                end else begin
                    err_inc = 1'b1;
                    next    = m_axis_mm2s_cntrl_tlast ? S_HDR : S_DRAIN;
                end
            end
            S_KEY: if (accept) begin
                store = 1'b1;
                if (m_axis_mm2s_cntrl_tkeep != 4'hF || (m_axis_mm2s_cntrl_tlast && !last_word)) begin
                    err_inc = 1'b1;
                    next    = m_axis_mm2s_cntrl_tlast ? S_HDR : S_DRAIN;
                end else if (last_word) begin
                    if (m_axis_mm2s_cntrl_tlast) begin
                        next        = S_COMMIT;
                        pend_set    = 1'b1;
                        pend_load_d = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                        next    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: if (accept && m_axis_mm2s_cntrl_tlast) next = S_HDR;
            S_COMMIT: if (aes_idle) begin
                commit = 1'b1;
                next   = S_HDR;
            end
            default: next = S_HDR;
        endcase
    end

    always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_cntrl_reset_out_n) begin
        if (!mm2s_cntrl_reset_out_n) begin
            cnt             <= '0;
            shadow          <= '0;
            pend_load       <= 1'b0;
            aes_key         <= '0;
            aes_key_valid   <= 1'b0;
            aes_key_update  <= 1'b0;
            aes_key_err_cnt <= '0;
        end else begin
            aes_key_update <= commit;
            if (cnt_clr)
                cnt <= '0;
            else if (store)
                cnt <= cnt + 1'b1;
            // first key word of the packet lands in the most significant slot
            if (store)
                shadow[(C_KEY_WORDS - 1 - int'(cnt)) * 32 +: 32] <= key_word;
            if (pend_set)
                pend_load <= pend_load_d;
            if (commit) begin
                aes_key       <= pend_load ? shadow : '0;
                aes_key_valid <= pend_load;
            end
            if (err_inc && aes_key_err_cnt != '1)
                aes_key_err_cnt <= aes_key_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_key_loader.sv
// Directed testbench for aes_key_loader: loads, stalls, malformed packets, clear, saturation, reset.
module tb_aes_key_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  tdata;
    logic [3:0]   tkeep;
    logic         tvalid;
    logic         tlast;
    logic         tready;
    logic         aes_idle;
    logic [255:0] aes_key;
    logic         aes_key_valid;
    logic         aes_key_update;
    logic [7:0]   aes_key_err_cnt;
    logic         aes_key_busy;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int upd_snap;
    logic [31:0]  words_a [8];
    logic [31:0]  words_b [8];
    logic [255:0] key_a, key_b, key_c, key_prev;

    aes_key_loader dut (
        .m_axi_mm2s_aclk          (clk),
        .mm2s_cntrl_reset_out_n   (rst_n),
        .m_axis_mm2s_cntrl_tdata  (tdata),
        .m_axis_mm2s_cntrl_tkeep  (tkeep),
        .m_axis_mm2s_cntrl_tvalid (tvalid),
        .m_axis_mm2s_cntrl_tlast  (tlast),
        .m_axis_mm2s_cntrl_tready (tready),
        .aes_idle                 (aes_idle),
        .aes_key                  (aes_key),
        .aes_key_valid            (aes_key_valid),
        .aes_key_update           (aes_key_update),
        .aes_key_err_cnt          (aes_key_err_cnt),
        .aes_key_busy             (aes_key_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (aes_key_update === 1'b1) upd_cnt++;

    function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef AES_KEY_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic send(input logic [31:0] d, input logic last, input logic [3:0] keep);
        int n = 0;
        @(negedge clk);
        tdata = d; tlast = last; tkeep = keep; tvalid = 1'b1;
        while (tready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (tready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: tready=%b required 1", tready);
        end
        @(posedge clk);
        #1 tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_load(input logic [31:0] w [8]);
        send(32'hA0000001, 1'b0, 4'hF);
        for (int i = 0; i < 8; i++) send(w[i], i == 7, 4'hF);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = 4'hF; aes_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({aes_key, aes_key_valid, aes_key_update, aes_key_err_cnt, tready, aes_key_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: key=%h valid=%b upd=%b err=%0d tready=%b busy=%b required all 0",
                     aes_key, aes_key_valid, aes_key_update, aes_key_err_cnt, tready, aes_key_busy);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL reset_tready_after: got %b required 1", tready); end
    endtask

    task automatic test_load;
        upd_snap = upd_cnt;
        send_load(words_a);
        checks++;
        if (tready !== 1'b0 || aes_key_busy !== 1'b1) begin
            errors++; $display("FAIL load_commit_state: tready=%b busy=%b required 0/1", tready, aes_key_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (aes_key !== key_a || aes_key_valid !== 1'b1 || aes_key_update !== 1'b1) begin
            errors++; $display("FAIL load_key: key=%h valid=%b upd=%b required %h/1/1", aes_key, aes_key_valid, aes_key_update, key_a);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (upd_cnt - upd_snap !== 1 || aes_key_err_cnt !== 8'd0 || aes_key_busy !== 1'b0) begin
            errors++; $display("FAIL load_pulse: pulses=%0d err=%0d busy=%b required 1/0/0", upd_cnt - upd_snap, aes_key_err_cnt, aes_key_busy);
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        upd_snap = upd_cnt;
        aes_idle = 1'b0;
        send_load(words_b);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (tready !== 1'b0 || aes_key !== key_a) bad++;
        end
        checks++;
        if (bad != 0 || upd_cnt != upd_snap) begin
            errors++; $display("FAIL stall_hold: bad_cycles=%0d pulses=%0d required 0/0", bad, upd_cnt - upd_snap);
        end
        aes_idle = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (aes_key !== key_b || aes_key_update !== 1'b1 || tready !== 1'b1) begin
            errors++; $display("FAIL stall_commit: key=%h upd=%b tready=%b required %h/1/1", aes_key, aes_key_update, tready, key_b);
        end
    endtask

    task automatic test_short;
        send(32'hA0000001, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) send(words_a[i], i == 2, 4'hF);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (aes_key_err_cnt !== 8'd1 || aes_key !== key_b || aes_key_valid !== 1'b1 || aes_key_busy !== 1'b0) begin
            errors++; $display("FAIL short_pkt: err=%0d key=%h valid=%b busy=%b required 1/%h/1/0", aes_key_err_cnt, aes_key, aes_key_valid, aes_key_busy, key_b);
        end
        send_load(words_a);
        @(posedge clk); #1;
        checks++;
        if (aes_key !== key_a || aes_key_valid !== 1'b1) begin
            errors++; $display("FAIL short_reload: key=%h required %h", aes_key, key_a);
        end
    endtask

    task automatic test_bad_flag;
        send(32'h50000001, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            send(32'hA0000002, 1'b0, 4'hF);
        end
        #1;
        checks++;
        if (aes_key_busy !== 1'b1 || aes_key_err_cnt !== 8'd2) begin
            errors++; $display("FAIL badflag_drain: busy=%b err=%0d required 1/2", aes_key_busy, aes_key_err_cnt);
        end
        send(32'hA0000002, 1'b1, 4'hF);
        #1;
        checks++;
        if (aes_key_busy !== 1'b0 || aes_key_err_cnt !== 8'd2 || aes_key !== key_a) begin
            errors++; $display("FAIL badflag_done: busy=%b err=%0d key=%h required 0/2/%h", aes_key_busy, aes_key_err_cnt, aes_key, key_a);
        end
        send(32'hA0000001, 1'b0, 4'hF);
        for (int i = 0; i < 8; i++) send(words_b[i], 1'b0, 4'hF);
        send(32'hA0000002, 1'b1, 4'hF);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (aes_key_err_cnt !== 8'd3 || aes_key !== key_a || aes_key_busy !== 1'b0) begin
            errors++; $display("FAIL notlast_drain: err=%0d key=%h busy=%b required 3/%h/0", aes_key_err_cnt, aes_key, aes_key_busy, key_a);
        end
        send(32'hA0000002, 1'b1, 4'h7);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (aes_key_err_cnt !== 8'd4 || aes_key_valid !== 1'b1) begin
            errors++; $display("FAIL tkeep_hdr: err=%0d valid=%b required 4/1", aes_key_err_cnt, aes_key_valid);
        end
    endtask

    task automatic test_clear;
        upd_snap = upd_cnt;
        send(32'hA0000002, 1'b1, 4'hF);
        @(posedge clk); #1;
        checks++;
        if (aes_key !== '0 || aes_key_valid !== 1'b0 || aes_key_update !== 1'b1) begin
            errors++; $display("FAIL clear: key=%h valid=%b upd=%b required 0/0/1", aes_key, aes_key_valid, aes_key_update);
        end
        for (int i = 0; i < 300; i++) send(32'h0, 1'b1, 4'hF);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (aes_key_err_cnt !== 8'd255 || upd_cnt - upd_snap !== 1) begin
            errors++; $display("FAIL err_saturate: err=%0d pulses=%0d required 255/1", aes_key_err_cnt, upd_cnt - upd_snap);
        end
    endtask

    task automatic test_reset_mid;
        send_load(words_a);
        @(posedge clk);
        send(32'hA0000001, 1'b0, 4'hF);
        for (int i = 0; i < 4; i++) send(words_b[i], 1'b0, 4'hF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (aes_key !== '0 || aes_key_valid !== 1'b0 || aes_key_err_cnt !== 8'd0 || tready !== 1'b0 || aes_key_busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: key=%h valid=%b err=%0d tready=%b busy=%b required 0", aes_key, aes_key_valid, aes_key_err_cnt, tready, aes_key_busy);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 4; i < 8; i++) send(words_b[i], i == 7, 4'hF);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (aes_key_err_cnt !== 8'd1 || aes_key !== '0 || aes_key_valid !== 1'b0 || aes_key_busy !== 1'b0) begin
            errors++; $display("FAIL reset_resume: err=%0d key=%h valid=%b busy=%b required 1/0/0/0", aes_key_err_cnt, aes_key, aes_key_valid, aes_key_busy);
        end
        send(32'hA0000001, 1'b0, 4'hF);
        for (int i = 0; i < 8; i++) send(i == 0 ? 32'h00112233 : 32'h0, i == 7, 4'hF);
        @(posedge clk); #1;
        checks++;
        if (aes_key !== key_c || aes_key_valid !== 1'b1) begin
            errors++; $display("FAIL bswap_word: key=%h required %h", aes_key, key_c);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            words_a[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            words_b[i] = ~words_a[i];
            key_a[255-32*i -: 32] = stored(words_a[i]);
            key_b[255-32*i -: 32] = stored(words_b[i]);
        end
        key_c = '0;
        key_c[255:224] = stored(32'h00112233);
        key_prev = key_a;
        test_reset;
        test_load;
        test_stall;
        test_short;
        test_bad_flag;
        test_clear;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
